// File: rtl/fp_divider_pkg.sv
// Shared constants, field helpers, result record and FSM states for the FP32 divider.
// Optional feature macro: FP_DIV_EARLY_EXIT_EN (see fp_divider.sv).
package fp_divider_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int FP_W    = 1 + EXP_W + MAN_W;
    localparam int EXP_LSB = MAN_W;
    localparam int ITERS   = MAN_W + 3;
    localparam int REM_W   = MAN_W + 3;
    localparam int CNT_W   = $clog2(ITERS + 1);
    localparam int E_W     = EXP_W + 2;

    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [E_W-1:0] E_ZERO   = '0;
    localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
    localparam logic signed [E_W-1:0] E_BIAS   = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_MAX    = E_W'(2**EXP_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic [FP_W-1:0] quot;
        logic            exception;
        logic            overflow;
        logic            underflow;
        logic            div_by_zero;
    } res_t;

    function automatic logic [FP_W-1:0] inf_of(input logic sign);
        return {sign, EXP_ONES, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [FP_W-1:0] zero_of(input logic sign);
        return {sign, {(FP_W-1){1'b0}}};
    endfunction

    // Only meaningful when one operand is Inf/NaN or zero; priority exception > div-by-zero > zero dividend.
    function automatic res_t special_result(input logic sign, input logic [EXP_W-1:0] ea,
                                            input logic [EXP_W-1:0] eb);
        res_t r;
        r = '0;
        if (ea == EXP_ONES || eb == EXP_ONES || (ea == '0 && eb == '0)) begin
            r.exception = 1'b1;
        end else if (eb == '0) begin
            r.quot        = inf_of(sign);
            r.div_by_zero = 1'b1;
        end else begin
            r.quot = zero_of(sign);
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for the FP32 divider.
interface fp_divider_if;
    import fp_divider_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] A;
    logic [FP_W-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] quot;
    logic            exception;
    logic            overflow;
    logic            underflow;
    logic            div_by_zero;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, quot, exception, overflow, underflow, div_by_zero
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, quot, exception, overflow, underflow, div_by_zero
    );

endinterface

// File: rtl/fp_divider_round.sv
// Combinational normalize, round-to-nearest-even and overflow/underflow select for the divider quotient.
module fp_div_round
    import fp_divider_pkg::*;
(
    input  logic                  sign,
    input  logic signed [E_W-1:0] e,
    input  logic [ITERS-1:0]      q,
    input  logic                  sticky,
    output res_t                  res
);

    // q = hidden bit, MAN_W fraction bits, guard, round; result carries one extra bit for carry-out.
    function automatic logic [MAN_W+1:0] rne(input logic [ITERS-1:0] qv, input logic st);
        logic up;
        up = qv[1] & (qv[0] | st | qv[2]);
        return {1'b0, qv[ITERS-1:2]} + {{(MAN_W+1){1'b0}}, up};
    endfunction

    logic [MAN_W+1:0]      mant;
    logic signed [E_W-1:0] e_adj;
    logic                  unused_hidden;

    always_comb begin
        mant  = rne(q, sticky);
        e_adj = e + $signed({{(E_W-1){1'b0}}, mant[MAN_W+1]});
        res   = '0;
        if (e_adj >= E_MAX) begin
            res.quot     = inf_of(sign);
            res.overflow = 1'b1;
        end else if (e_adj <= E_ZERO) begin
            res.quot      = zero_of(sign);
            res.underflow = 1'b1;
        end else begin
            res.quot = {sign, e_adj[EXP_W-1:0],
                        (mant[MAN_W+1] ? {MAN_W{1'b0}} : mant[MAN_W-1:0])};
        end
    end

    assign unused_hidden = mant[MAN_W];

endmodule

// File: rtl/fp_divider.sv
// Sequential FP32 divider: radix-2 restoring mantissa loop, one quotient bit per cycle, valid/ready both sides.
// Define FP_DIV_EARLY_EXIT_EN to leave the loop as soon as the partial remainder reaches zero.
module fp_divider
    import fp_divider_pkg::*;
(
    input logic         clk,
    input logic         rst,
    fp_divider_if.slave bus
);

    state_t state, state_nxt;

    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W:0]        ma, mb;
    logic signed [E_W-1:0] ea_s, eb_s, e_init;
    logic                  special, pre, accept;
    logic [REM_W-1:0]      rem_init;
    res_t                  special_res;

    logic [REM_W-1:0]      rem_r;
    logic [ITERS-1:0]      q_r;
    logic signed [E_W-1:0] e_r;
    logic [MAN_W:0]        mb_r;
    logic                  sign_r;
    res_t                  special_r;
    logic [CNT_W-1:0]      cnt_r;
    res_t                  res_q;

    logic [REM_W-1:0]      rem_sub, rem_nxt;
    logic                  ge, loop_done;
    logic [CNT_W-1:0]      fill_sh;
    res_t                  round_res;

    // Operand unpack at accept; a smaller dividend significand is pre-shifted so q's top bit is 1.
    always_comb begin
        ea          = bus.A[EXP_LSB +: EXP_W];
        eb          = bus.B[EXP_LSB +: EXP_W];
        ma          = {1'b1, bus.A[MAN_W-1:0]};
        mb          = {1'b1, bus.B[MAN_W-1:0]};
        special     = (ea == EXP_ONES) || (eb == EXP_ONES) || (ea == '0) || (eb == '0);
        pre         = ma < mb;
        ea_s        = $signed({2'b00, ea});
        eb_s        = $signed({2'b00, eb});
        e_init      = ea_s - eb_s + E_BIAS - (pre ? E_ONE : E_ZERO);
        rem_init    = pre ? {1'b0, ma, 1'b0} : {2'b00, ma};
        special_res = special_result(bus.A[FP_W-1] ^ bus.B[FP_W-1], ea, eb);
        accept      = (state == IDLE) && bus.in_valid;
    end

    always_comb begin
        ge      = rem_r >= {2'b00, mb_r};
        rem_sub = rem_r - {2'b00, mb_r};
        rem_nxt = ge ? rem_sub : rem_r;
        fill_sh = CNT_W'(ITERS) - cnt_r;
`ifdef FP_DIV_EARLY_EXIT_EN
        loop_done = (cnt_r == CNT_W'(ITERS)) || (rem_r == '0);
`else
        loop_done = (cnt_r == CNT_W'(ITERS));
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = special ? SPECIAL : DIVIDE;
            SPECIAL: state_nxt = DONE;
            DIVIDE:  if (loop_done) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_r <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt_r <= '0;
            end else if (state == DIVIDE && !loop_done) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (state == NORM) begin
                res_q <= round_res;
            end else if (state == SPECIAL) begin
                res_q <= special_r;
            end
        end
    end

    // Loop datapath; an early exit left-aligns the partial quotient, zero-filling the untried bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_r     <= rem_init;
            q_r       <= '0;
            e_r       <= e_init;
            mb_r      <= mb;
            sign_r    <= bus.A[FP_W-1] ^ bus.B[FP_W-1];
            special_r <= special_res;
        end else if (state == DIVIDE) begin
            if (loop_done) begin
                q_r <= q_r << fill_sh;
            end else begin
                rem_r <= rem_nxt << 1;
                q_r   <= {q_r[ITERS-2:0], ge};
            end
        end
    end

    fp_div_round u_round (
        .sign   (sign_r),
        .e      (e_r),
        .q      (q_r),
        .sticky (|rem_r),
        .res    (round_res)
    );

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quot        = res_q.quot;
    assign bus.exception   = res_q.exception;
    assign bus.overflow    = res_q.overflow;
    assign bus.underflow   = res_q.underflow;
    assign bus.div_by_zero = res_q.div_by_zero;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: directed corner cases plus randomized operands against an exact-arithmetic model.
module tb_fp_divider;

    typedef struct {
        logic [31:0] quot;
        logic [3:0]  flags;   // {exception, overflow, underflow, div_by_zero}
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errs;
    int   rdy_mode;
    exp_t exp_q[$];

    fp_divider_if bus();

    fp_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Exact integer quotient of the significands, rounded by comparing twice the remainder with the divisor.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t            r;
        int              ea, eb, e, sh, tz;
        logic            s;
        longint unsigned ma, mb, num, qm, rm, q26;
        r.quot = 32'd0; r.flags = 4'd0; r.lat = 1; r.acc = 0; r.name = "";
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
            r.flags = 4'b1000;
        end else if (eb == 0) begin
            r.quot  = {s, 8'hFF, 23'd0};
            r.flags = 4'b0001;
        end else if (ea == 0) begin
            r.quot = {s, 31'd0};
        end else begin
            ma = {40'd0, 1'b1, a[22:0]};
            mb = {40'd0, 1'b1, b[22:0]};
            e  = ea - eb + 127;
            sh = 23;
            if (ma < mb) begin sh = 24; e = e - 1; end
            num = ma << sh;
            qm  = num / mb;
            rm  = num % mb;
            if (2 * rm > mb || (2 * rm == mb && qm[0])) qm = qm + 1;
            if (qm == (64'd1 << 24)) begin qm = qm >> 1; e = e + 1; end
            if (e >= 255) begin
                r.quot = {s, 8'hFF, 23'd0}; r.flags = 4'b0100;
            end else if (e <= 0) begin
                r.quot = {s, 31'd0}; r.flags = 4'b0010;
            end else begin
                r.quot = {s, e[7:0], qm[22:0]};
            end
            r.lat = 28;
`ifdef FP_DIV_EARLY_EXIT_EN
            q26 = (ma << (sh + 2)) / mb;
            if (((ma << (sh + 2)) % mb) == 0) begin
                tz = 0;
                while (q26[0] == 1'b0) begin q26 = q26 >> 1; tz++; end
                r.lat = 26 - tz + 2;
            end
`else
            q26 = 0; tz = 0;
`endif
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] q, input logic [3:0] f, input int lat);
        exp_t r;
        r.quot = q; r.flags = f; r.lat = lat; r.acc = 0; r.name = "";
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] ex;
        case ($urandom_range(0, 19))
            0:       ex = 8'd0;
            1:       ex = 8'hFF;
            2:       ex = 8'($urandom_range(1, 5));
            3:       ex = 8'($urandom_range(250, 254));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    // Called in the posedge+1 phase; returns in the same phase after the accepting edge.
    task automatic send(input string name, input logic [31:0] a, input logic [31:0] b, input exp_t e_in);
        exp_t e;
        int   waited;
        e = e_in;
        e.name = name;
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s accept_timeout: in_ready=0 required 1", name);
            bus.in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor: latency on first sight, hold stability while stalled, pop and compare on transfer.
    initial begin : monitor
        logic        held;
        logic [35:0] held_val, cur;
        exp_t        e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else if (bus.out_valid) begin
                cur = {bus.quot, bus.exception, bus.overflow, bus.underflow, bus.div_by_zero};
                check("in_ready_busy", 64'(bus.in_ready), 64'd0);
                if (held) begin
                    check("hold_stable", 64'(cur), 64'(held_val));
                end else begin
                    held     = 1'b1;
                    held_val = cur;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_output: quot=%h required no output", bus.quot);
                    end else begin
                        check({exp_q[0].name, "_latency"}, 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    end
                end
                if (bus.out_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check({e.name, "_quot"}, 64'(cur[35:4]), 64'(e.quot));
                        check({e.name, "_flags"}, 64'(cur[3:0]), 64'(e.flags));
                    end
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a, b;
        int          n;
        n_checks = 0;
        n_errs   = 0;
        cyc      = 0;
        rdy_mode = 0;
        rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_quot", 64'(bus.quot), 64'd0);
        check("rst_flags", 64'({bus.exception, bus.overflow, bus.underflow, bus.div_by_zero}), 64'd0);
        @(posedge clk);
        #1;

        send("div_6_2",   32'h40C00000, 32'h40000000, mk(32'h40400000, 4'b0000, model(32'h40C00000, 32'h40000000).lat));
        send("div_1_3",   32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 4'b0000, model(32'h3F800000, 32'h40400000).lat));
        send("div_by_0",  32'h3F800000, 32'h00000000, mk(32'h7F800000, 4'b0001, 1));
        send("inf_by_0",  32'h7F800000, 32'h00000000, mk(32'h00000000, 4'b1000, 1));
        send("zero_zero", 32'h00000000, 32'h00000000, mk(32'h00000000, 4'b1000, 1));
        send("neg_zero",  32'h80000000, 32'h3F800000, mk(32'h80000000, 4'b0000, 1));
        send("ovf",       32'h7F000000, 32'h00800000, mk(32'h7F800000, 4'b0100, model(32'h7F000000, 32'h00800000).lat));
        send("unf",       32'h00800000, 32'h7F000000, mk(32'h00000000, 4'b0010, model(32'h00800000, 32'h7F000000).lat));
        send("neg_6_2",   32'hC0C00000, 32'h40000000, mk(32'hC0400000, 4'b0000, model(32'hC0C00000, 32'h40000000).lat));
`ifdef FP_DIV_EARLY_EXIT_EN
        send("div_4_2",   32'h40800000, 32'h40000000, mk(32'h40000000, 4'b0000, 3));
`else
        send("div_4_2",   32'h40800000, 32'h40000000, mk(32'h40000000, 4'b0000, 28));
`endif
        wait_drain();

        // Consumer stalls: result must hold with in_ready low.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send("stall_1_3", 32'h3F800000, 32'h40400000, mk(32'h3EAAAAAB, 4'b0000, model(32'h3F800000, 32'h40400000).lat));
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        rdy_mode = 0;
        wait_drain();

        // Reset in the middle of the mantissa loop.
        send("rst_mid", 32'h40C00000, 32'h40000000, mk(32'h40400000, 4'b0000, 28));
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            if ($urandom_range(0, 3) == 0) b[22:0] = ($urandom_range(0, 1) == 1) ? a[22:0] : 23'd0;
            send($sformatf("rnd%0d", i), a, b, model(a, b));
        end
        rdy_mode = 0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
